// File: rtl/floating_point_rounder.sv
// floating_point_rounder
// Rounding and exception-finalisation stage for float32 results. It applies
// the RISC-V rounding mode, fixes up overflow (upstream or caused by rounding),
// builds the {NV,DZ,OF,UF,NX} flag vector and keeps sticky accumulated flags.
// One registered output stage with a valid/ready handshake.
// Optional feature macro: ROUNDER_CANONICAL_NAN_EN (invalid beats return the
// RISC-V canonical NaN instead of passing result_i through).
module floating_point_rounder (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        data_valid_i,
  output logic        ready_o,
  input  logic [31:0] result_i,
  input  logic [2:0]  round_bits_i,
  input  logic [2:0]  rounding_mode_i,
  input  logic        invalid_operation_i,
  input  logic        overflow_i,
  input  logic        underflow_i,
  output logic        data_valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic [4:0]  flags_o,
  output logic [4:0]  fflags_o,
  input  logic        fflags_clear_i
);

  localparam logic [2:0]  RM_RNE = 3'd0;
  localparam logic [2:0]  RM_RTZ = 3'd1;
  localparam logic [2:0]  RM_RDN = 3'd2;
  localparam logic [2:0]  RM_RUP = 3'd3;
  localparam logic [2:0]  RM_RMM = 3'd4;
  localparam logic [30:0] MAG_INF = 31'h7F800000;
  localparam logic [30:0] MAG_MAX = 31'h7F7FFFFF;

  logic        sign;
  logic [7:0]  exponent;
  logic        g, r, s, lsb, any;
  logic        inc;
  logic        to_inf;
  logic [30:0] mag_inc;
  logic [31:0] sat_result;
  logic [31:0] next_result;
  logic [4:0]  next_flags;
  logic        capture;
  logic        out_hs;
  logic [4:0]  hs_flags;

  assign sign     = result_i[31];
  assign exponent = result_i[30:23];
  assign lsb      = result_i[0];
  assign {g, r, s} = round_bits_i;
  assign any      = g | r | s;

  assign ready_o  = !data_valid_o | ready_i;
  assign capture  = data_valid_i & ready_o;
  assign out_hs   = data_valid_o & ready_i;
  assign hs_flags = out_hs ? flags_o : 5'd0;

  // Increment decision and overflow saturation direction from the rounding mode
  always_comb begin
    inc    = 1'b0;
    to_inf = 1'b1;
    case (rounding_mode_i)
      RM_RTZ: begin
        inc    = 1'b0;
        to_inf = 1'b0;
      end
      RM_RDN: begin
        inc    = sign & any;
        to_inf = sign;
      end
      RM_RUP: begin
        inc    = !sign & any;
        to_inf = !sign;
      end
      RM_RMM: begin
        inc    = g;
        to_inf = 1'b1;
      end
      default: begin
        // RNE, and reserved encodings 5-7 behave as RNE
        inc    = g & (r | s | lsb);
        to_inf = 1'b1;
      end
    endcase
  end

  assign mag_inc    = result_i[30:0] + {30'd0, inc};
  assign sat_result = {sign, to_inf ? MAG_INF : MAG_MAX};

  // Result and flag selection; invalid wins, then upstream overflow/underflow,
  // then inf/NaN passthrough, then ordinary rounding
  always_comb begin
    next_result = result_i;
    next_flags  = 5'b00000;
    if (invalid_operation_i) begin
`ifdef ROUNDER_CANONICAL_NAN_EN
      next_result = 32'h7FC00000;
`else
      next_result = result_i;
`endif
      next_flags  = 5'b10000;
    end else if (overflow_i) begin
      next_result = sat_result;
      next_flags  = 5'b00101;
    end else if (underflow_i) begin
      next_result = result_i;
      next_flags  = 5'b00011;
    end else if (exponent == 8'hFF) begin
      next_result = result_i;
      next_flags  = 5'b00000;
    end else if (mag_inc[30:23] == 8'hFF) begin
      next_result = sat_result;
      next_flags  = 5'b00101;
    end else begin
      next_result = {sign, mag_inc};
      next_flags  = {4'b0000, any};
    end
  end

  // Output register stage: capture on input handshake, drop valid when drained
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_valid_o <= 1'b0;
      result_o     <= 32'd0;
      flags_o      <= 5'd0;
    end else if (capture) begin
      data_valid_o <= 1'b1;
      result_o     <= next_result;
      flags_o      <= next_flags;
    end else if (out_hs) begin
      data_valid_o <= 1'b0;
    end
  end

  // Sticky flag accumulator, updated only by beats leaving on the output handshake
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fflags_o <= 5'd0;
    end else if (fflags_clear_i) begin
      fflags_o <= hs_flags;
    end else begin
      fflags_o <= fflags_o | hs_flags;
    end
  end

endmodule

// File: tb/tb_floating_point_rounder.sv
// tb_floating_point_rounder
// Directed test-plan vectors plus a randomized stream with random backpressure,
// checked against an arithmetic reference model and a one-deep expected queue.
module tb_floating_point_rounder;

  logic        clk_i;
  logic        rst_n_i;
  logic        data_valid_i;
  logic        ready_o;
  logic [31:0] result_i;
  logic [2:0]  round_bits_i;
  logic [2:0]  rounding_mode_i;
  logic        invalid_operation_i;
  logic        overflow_i;
  logic        underflow_i;
  logic        data_valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic [4:0]  flags_o;
  logic [4:0]  fflags_o;
  logic        fflags_clear_i;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q[$];
  logic [4:0]  model_ff = 5'd0;

  floating_point_rounder dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_valid_i(data_valid_i), .ready_o(ready_o),
    .result_i(result_i), .round_bits_i(round_bits_i), .rounding_mode_i(rounding_mode_i),
    .invalid_operation_i(invalid_operation_i), .overflow_i(overflow_i),
    .underflow_i(underflow_i), .data_valid_o(data_valid_o), .ready_i(ready_i),
    .result_o(result_o), .flags_o(flags_o), .fflags_o(fflags_o),
    .fflags_clear_i(fflags_clear_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Reference: magnitude as an unsigned integer, bumped by one when rounding up
  function automatic logic [36:0] ref_round(input logic [31:0] x, input logic [2:0] grs,
                                            input logic [2:0] rm, input logic inv,
                                            input logic ovf, input logic unf);
    int unsigned mag;
    int          mode;
    bit          sgn, up, to_inf;
    logic [31:0] sat, res;
    logic [4:0]  fl;
    mag  = {1'b0, x[30:0]};
    sgn  = x[31];
    mode = (rm > 3'd4) ? 0 : int'(rm);
    to_inf = (mode == 0) || (mode == 4) || (mode == 3 && !sgn) || (mode == 2 && sgn);
    sat  = to_inf ? {sgn, 31'h7F800000} : {sgn, 31'h7F7FFFFF};
    case (mode)
      0: up = grs[2] && (grs[1] || grs[0] || x[0]);
      1: up = 1'b0;
      2: up = sgn && (grs != 3'b000);
      3: up = !sgn && (grs != 3'b000);
      default: up = grs[2];
    endcase
    if (inv) begin
`ifdef ROUNDER_CANONICAL_NAN_EN
      res = 32'h7FC00000;
`else
      res = x;
`endif
      fl = 5'b10000;
    end else if (ovf) begin
      res = sat; fl = 5'b00101;
    end else if (unf) begin
      res = x; fl = 5'b00011;
    end else if (x[30:23] == 8'hFF) begin
      res = x; fl = 5'b00000;
    end else begin
      mag = mag + (up ? 1 : 0);
      if (mag >= 32'h7F800000) begin
        res = sat; fl = 5'b00101;
      end else begin
        res = {sgn, mag[30:0]};
        fl  = (grs != 3'b000) ? 5'b00001 : 5'b00000;
      end
    end
    return {res, fl};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: check outputs against the queue model mid-cycle, then advance
  task automatic tick();
    logic       mvalid, hs;
    logic [4:0] hsf;
    @(negedge clk_i);
    mvalid = (exp_q.size() != 0);
    chk("valid_o", {31'd0, data_valid_o}, {31'd0, mvalid});
    chk("ready_o", {31'd0, ready_o}, {31'd0, (!mvalid || ready_i)});
    chk("fflags_o", {27'd0, fflags_o}, {27'd0, model_ff});
    if (mvalid) begin
      chk("result_o", result_o, exp_q[0][36:5]);
      chk("flags_o", {27'd0, flags_o}, {27'd0, exp_q[0][4:0]});
    end
    hs  = mvalid && ready_i;
    hsf = hs ? exp_q[0][4:0] : 5'd0;
    model_ff = fflags_clear_i ? hsf : (model_ff | hsf);
    if (hs) void'(exp_q.pop_front());
    if (data_valid_i && (!mvalid || ready_i))
      exp_q.push_back(ref_round(result_i, round_bits_i, rounding_mode_i,
                                invalid_operation_i, overflow_i, underflow_i));
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] x, input logic [2:0] grs,
                       input logic [2:0] rm, input logic inv, input logic ovf,
                       input logic unf, input logic rdy);
    data_valid_i = v; result_i = x; round_bits_i = grs; rounding_mode_i = rm;
    invalid_operation_i = inv; overflow_i = ovf; underflow_i = unf; ready_i = rdy;
  endtask

  // Single beat with ready_i=1; afterwards the captured beat sits on the outputs
  task automatic beat(input logic [31:0] x, input logic [2:0] grs, input logic [2:0] rm,
                      input logic [31:0] exp_res, input logic [4:0] exp_fl, input string tag);
    drive(1'b1, x, grs, rm, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk({tag, "_res"}, result_o, exp_res);
    chk({tag, "_flg"}, {27'd0, flags_o}, {27'd0, exp_fl});
    drive(1'b0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  initial begin
    logic [31:0] rx;
    logic [2:0]  sel;
    fflags_clear_i = 1'b0;
    drive(1'b0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n_i = 1'b0;
    #12;
    chk("rst_valid", {31'd0, data_valid_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_flags", {27'd0, flags_o}, 32'd0);
    chk("rst_fflags", {27'd0, fflags_o}, 32'd0);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    beat(32'h3F800000, 3'b100, 3'd0, 32'h3F800000, 5'b00001, "rne_tie_even");
    beat(32'h3F800001, 3'b100, 3'd0, 32'h3F800002, 5'b00001, "rne_tie_odd");
    beat(32'h3FFFFFFF, 3'b110, 3'd0, 32'h40000000, 5'b00001, "mant_carry");
    beat(32'h7F7FFFFF, 3'b100, 3'd0, 32'h7F800000, 5'b00101, "ovf_rne");
    beat(32'h7F7FFFFF, 3'b100, 3'd1, 32'h7F7FFFFF, 5'b00001, "ovf_rtz");
    beat(32'hBF800000, 3'b001, 3'd2, 32'hBF800001, 5'b00001, "rdn_neg");
    beat(32'hBF800000, 3'b001, 3'd3, 32'hBF800000, 5'b00001, "rup_neg");
    beat(32'h3F800000, 3'b100, 3'd6, 32'h3F800000, 5'b00001, "rm6_as_rne");

    // Backpressure: A captured, then B held off for two cycles, then B and C flow
    fflags_clear_i = 1'b1;
    tick();
    fflags_clear_i = 1'b0;
    drive(1'b1, 32'h00000000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h7F800001, 3'b000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_ready_low", {31'd0, ready_o}, 32'd0);
    tick();
    chk("bp_hold_res", result_o, 32'h00000000);
    chk("bp_hold_flg", {27'd0, flags_o}, 32'h00000003);
    ready_i = 1'b1;
    tick();
    drive(1'b1, 32'hFF800000, 3'b000, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("bp_c_res", result_o, 32'hFF7FFFFF);
    drive(1'b0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("bp_fflags_or", {27'd0, fflags_o}, 32'h00000017);

    // Invalid beat, then clear with no handshake pending
`ifdef ROUNDER_CANONICAL_NAN_EN
    drive(1'b1, 32'h7F800001, 3'b101, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("inv_res", result_o, 32'h7FC00000);
`else
    drive(1'b1, 32'h7F800001, 3'b101, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("inv_res", result_o, 32'h7F800001);
`endif
    chk("inv_flg", {27'd0, flags_o}, 32'h00000010);
    drive(1'b0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    fflags_clear_i = 1'b1;
    tick();
    fflags_clear_i = 1'b0;
    chk("clear_fflags", {27'd0, fflags_o}, 32'd0);

    // Randomized stream with random backpressure and occasional clears
    for (int i = 0; i < 400; i++) begin
      sel = 3'($urandom_range(0, 7));
      rx  = $urandom;
      if (sel == 3'd0) rx[30:23] = 8'hFF;
      if (sel == 3'd1) rx[30:0]  = 31'h7F7FFFFF;
      if (sel == 3'd2) rx[22:0]  = 23'h7FFFFF;
      drive($urandom_range(0, 3) != 0, rx, 3'($urandom), 3'($urandom),
            sel == 3'd3, sel == 3'd4, sel == 3'd5, $urandom_range(0, 2) != 0);
      fflags_clear_i = ($urandom_range(0, 15) == 0);
      tick();
    end
    fflags_clear_i = 1'b0;

    // Reset during a stall drops the pending beat immediately
    drive(1'b1, 32'h3F800000, 3'b111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n_i = 1'b0;
    #2;
    chk("midrst_valid", {31'd0, data_valid_o}, 32'd0);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_fflags", {27'd0, fflags_o}, 32'd0);
    exp_q.delete();
    model_ff = 5'd0;
    drive(1'b0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n_i = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
